// File: rtl/riscv_pkg.sv
// Shared loader constants and FSM state encoding.
// Build with LOADER_CHECKSUM_EN to add the checksum states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LOAD       = 3'd1,
        WRITE      = 3'd2,
        DONE       = 3'd3,
        CSUM_LOAD  = 3'd4,
        CSUM_CHECK = 3'd5
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3
    } loader_state_t;
`endif

endpackage

// File: rtl/byte_word_assembler.sv
// Collects a stream of bytes into little-endian 32-bit words; word_done
// is a combinational pulse on the byte that completes a word.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0] byte_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_reg <= 2'd0;
        end else if (clear) begin
            byte_cnt_reg <= 2'd0;
        end else if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    assign word_done = accept && (byte_cnt_reg == 2'd3);

    // One register per byte lane; lane 0 holds the first byte of the word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    lane_reg <= 8'd0;
                end else if (clear) begin
                    lane_reg <= 8'd0;
                end else if (accept && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/program_loader_arbiter.sv
// Shares the program memory port between CPU fetch and a byte-stream loader.
// LOADER_CHECKSUM_EN adds a trailing checksum word and the load_error output.
module program_loader_arbiter #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    output logic        cpu_restart,
    input  logic        load_start,
    input  logic [8:0]  load_words,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        load_busy,
    output logic        load_done,
    output logic [31:0] mem_byte_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic        load_error
`endif
);

    import riscv_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);
    localparam int TW = AW + 1;

    loader_state_t  state_reg, state_next;
    logic [AW-1:0]  word_cnt_reg;
    logic [TW-1:0]  target_reg;
    logic [TW-1:0]  target_next;
    logic [31:0]    req_words;
    logic           start_ok;
    logic           last_word;
    logic           accept;
    logic [31:0]    asm_word;
    logic           word_done;

    assign start_ok  = (state_reg == RUN) && load_start && (load_words != 9'd0);
    assign req_words = 32'(load_words);
    assign target_next = (req_words > 32'(MEM_WORDS)) ? TW'(MEM_WORDS) : TW'(req_words);
    assign last_word = ({1'b0, word_cnt_reg} == (target_reg - TW'(1)));

`ifdef LOADER_CHECKSUM_EN
    assign rx_ready = (state_reg == LOAD) || (state_reg == CSUM_LOAD);
`else
    assign rx_ready = (state_reg == LOAD);
`endif
    assign accept = rx_valid && rx_ready;

    byte_word_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .accept    (accept),
        .byte_data (rx_data),
        .word      (asm_word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= RUN;
            word_cnt_reg <= '0;
            target_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                word_cnt_reg <= '0;
                target_reg   <= target_next;
            end else if (state_reg == WRITE) begin
                word_cnt_reg <= word_cnt_reg + AW'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_reg;
    logic        load_error_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg        <= 32'd0;
            load_error_reg <= 1'b0;
        end else if (start_ok) begin
            sum_reg        <= 32'd0;
            load_error_reg <= 1'b0;
        end else if (state_reg == WRITE) begin
            sum_reg <= sum_reg + asm_word;
        end else if (state_reg == CSUM_CHECK) begin
            load_error_reg <= (asm_word != sum_reg);
        end
    end

    assign load_error = load_error_reg;
`endif

    // Outside RUN the CPU sees a stalled NOP and the port points at the load address.
    always_comb begin
        state_next       = state_reg;
        cpu_stall        = 1'b1;
        cpu_instr        = NOP_INSTR;
        cpu_restart      = 1'b0;
        load_busy        = 1'b1;
        load_done        = 1'b0;
        mem_byte_address = 32'({word_cnt_reg, 2'b00});
        mem_write_enable = 1'b0;
        mem_write_data   = asm_word;
        case (state_reg)
            RUN: begin
                cpu_stall        = 1'b0;
                cpu_instr        = mem_read_data;
                load_busy        = 1'b0;
                mem_byte_address = cpu_pc;
                if (start_ok) state_next = LOAD;
            end
            LOAD: begin
                if (word_done) state_next = WRITE;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_next = last_word ? CSUM_LOAD : LOAD;
`else
                state_next = last_word ? DONE : LOAD;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM_LOAD: begin
                if (word_done) state_next = CSUM_CHECK;
            end
            CSUM_CHECK: begin
                state_next = DONE;
            end
`endif
            DONE: begin
                load_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                cpu_restart = !load_error_reg;
`else
                cpu_restart = 1'b1;
`endif
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_program_loader_arbiter.sv
// Self-checking bench for program_loader_arbiter with a behavioural program
// memory and a write scoreboard; covers LOADER_CHECKSUM_EN when defined.
module tb_program_loader_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        cpu_restart;
    logic        load_start;
    logic [8:0]  load_words;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        load_busy;
    logic        load_done;
    logic [31:0] mem_byte_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
`ifdef LOADER_CHECKSUM_EN
    logic        load_error;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    program_loader_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_pc           (cpu_pc),
        .cpu_instr        (cpu_instr),
        .cpu_stall        (cpu_stall),
        .cpu_restart      (cpu_restart),
        .load_start       (load_start),
        .load_words       (load_words),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .load_busy        (load_busy),
        .load_done        (load_done),
        .mem_byte_address (mem_byte_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
`ifdef LOADER_CHECKSUM_EN
        ,
        .load_error       (load_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_write_enable) begin
            mem[mem_byte_address[9:2]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_byte_address[9:2]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    int vectors;
    int miscompares;
    int done_cnt;
    int restart_cnt;
    int wr_cnt;
    logic [31:0] last_wr_addr;
    logic [7:0]  stim [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_instr;
    } run_vec_t;

    typedef struct {
        int          words;
        int          gap_max;
        bit          mid_start;
        int          pattern;
        int          exp_writes;
        logic [31:0] exp_last_addr;
    } load_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("rx_ready_within_budget", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input int words);
        @(posedge clk);
        #1;
        load_words = 9'(words);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic do_load(input load_vec_t v, input bit csum_bad);
        int          d0, r0, w0, nbytes, exp_restart;
        logic [31:0] w, sum;
        bit          seen;
        d0 = done_cnt;
        r0 = restart_cnt;
        w0 = wr_cnt;
        sum = 32'd0;
        nbytes = v.exp_writes * 4;
        for (int i = 0; i < v.exp_writes; i++) begin
            w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            sum = sum + w;
            exp_q.push_back('{addr: 32'(i * 4), data: w});
        end
        pulse_start(v.words);
        check("busy_after_start", 32'(load_busy), 32'd1);
        for (int i = 0; i < nbytes; i++) begin
            if (v.gap_max > 0) begin
                repeat ($urandom_range(0, v.gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (v.mid_start && i == nbytes / 2 + 1) pulse_start(1);
            send_byte(stim[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        w = sum + (csum_bad ? 32'd1 : 32'd0);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        exp_restart = csum_bad ? 0 : 1;
`else
        exp_restart = csum_bad ? 0 : 1;
`endif
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (load_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("load_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("stall_low_after_done", 32'(cpu_stall), 32'd0);
        check("busy_low_after_done", 32'(load_busy), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("restart_pulses", 32'(restart_cnt - r0), 32'(exp_restart));
        check("write_count", 32'(wr_cnt - w0), 32'(v.exp_writes));
        check("last_write_addr", last_wr_addr, v.exp_last_addr);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("load_error", 32'(load_error), 32'(csum_bad));
`endif
        $display("load words=%0d gap_max=%0d writes=%0d last_addr=0x%08h", v.words, v.gap_max,
                 wr_cnt - w0, last_wr_addr);
    endtask

    run_vec_t  run_tab  [5];
    load_vec_t load_tab [3];

    initial begin
        int          w0;
        logic [31:0] old1;
        wr_t         e;

        run_tab[0] = '{pc: 32'h0000_0008, exp_instr: 32'hA000_0002};
        run_tab[1] = '{pc: 32'h0000_0000, exp_instr: 32'hA000_0000};
        run_tab[2] = '{pc: 32'h0000_03FC, exp_instr: 32'hA000_00FF};
        run_tab[3] = '{pc: 32'h0000_0014, exp_instr: 32'hA000_0005};
        run_tab[4] = '{pc: 32'h0000_0007, exp_instr: 32'hA000_0001};

        load_tab[0] = '{words: 2,   gap_max: 0, mid_start: 1'b0, pattern: 0, exp_writes: 2,   exp_last_addr: 32'h4};
        load_tab[1] = '{words: 2,   gap_max: 5, mid_start: 1'b0, pattern: 0, exp_writes: 2,   exp_last_addr: 32'h4};
        load_tab[2] = '{words: 300, gap_max: 0, mid_start: 1'b1, pattern: 1, exp_writes: 256, exp_last_addr: 32'h3FC};

        vectors = 0;
        miscompares = 0;
        done_cnt = 0;
        restart_cnt = 0;
        wr_cnt = 0;
        last_wr_addr = 32'd0;
        reset = 1'b0;
        preload = 1'b0;
        cpu_pc = 32'd0;
        load_start = 1'b0;
        load_words = 9'd0;
        rx_valid = 1'b0;
        rx_data = 8'd0;

        // Reset asserted between clock edges must take effect at once.
        #2 reset = 1'b1;
        #1;
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_cpu_restart", 32'(cpu_restart), 32'd0);
        check("rst_load_busy", 32'(load_busy), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (load_busy) check("nop_during_load", cpu_instr, NOP);
                    if (mem_write_enable || load_done)
                        check("rx_ready_low_write_done", 32'(rx_ready), 32'd0);
`ifndef LOADER_CHECKSUM_EN
                    if (load_busy && !mem_write_enable && !load_done)
                        check("rx_ready_high_in_load", 32'(rx_ready), 32'd1);
`endif
                    if (mem_write_enable) begin
                        wr_cnt++;
                        last_wr_addr = mem_byte_address;
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                                     mem_byte_address, mem_write_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("write_addr", mem_byte_address, e.addr);
                            check("write_data", mem_write_data, e.data);
                        end
                    end
                    if (load_done) begin
                        done_cnt++;
                        if (cpu_restart) restart_cnt++;
                    end
                    if (cpu_restart) check("restart_only_in_done", 32'(load_done), 32'd1);
                end
            end
        join_none

        // Fetch path is combinational in RUN.
        foreach (run_tab[i]) begin
            cpu_pc = run_tab[i].pc;
            #1;
            check("run_instr", cpu_instr, run_tab[i].exp_instr);
            check("run_addr", mem_byte_address, run_tab[i].pc);
            check("run_stall", 32'(cpu_stall), 32'd0);
            $display("run pc=0x%08h instr=0x%08h", cpu_pc, cpu_instr);
        end

        foreach (load_tab[i]) begin
            if (load_tab[i].pattern == 0) begin
                stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
                stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h20; stim[7] = 8'h00;
            end else begin
                for (int k = 0; k < 1024; k++) stim[k] = 8'(k);
            end
            do_load(load_tab[i], 1'b0);
        end

        // load_words == 0 is ignored.
        w0 = wr_cnt;
        pulse_start(0);
        repeat (4) begin
            @(negedge clk);
            check("zero_words_idle", 32'(load_busy), 32'd0);
        end
        check("zero_words_no_write", 32'(wr_cnt - w0), 32'd0);
        $display("load words=0 writes=%0d", wr_cnt - w0);

        // Reset after 6 bytes of a 3-word load keeps word 0 only.
        old1 = mem[1];
        w0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h4433_2211});
        pulse_start(3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h88); send_byte(8'h77);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midload_rst_stall", 32'(cpu_stall), 32'd0);
        check("midload_rst_busy", 32'(load_busy), 32'd0);
        check("midload_rst_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cpu_pc = 32'h0;
        #1 check("midload_word0", cpu_instr, 32'h4433_2211);
        cpu_pc = 32'h4;
        #1 check("midload_word1_kept", cpu_instr, old1);
        check("midload_writes", 32'(wr_cnt - w0), 32'd1);
        check("midload_scoreboard", 32'(exp_q.size()), 32'd0);
        $display("reset mid-load writes=%0d word1=0x%08h", wr_cnt - w0, cpu_instr);

`ifdef LOADER_CHECKSUM_EN
        stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        do_load('{words: 1, gap_max: 0, mid_start: 1'b0, pattern: 0, exp_writes: 1,
                  exp_last_addr: 32'h0}, 1'b0);
        do_load('{words: 1, gap_max: 0, mid_start: 1'b0, pattern: 0, exp_writes: 1,
                  exp_last_addr: 32'h0}, 1'b1);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
